// File: rtl/alu_share_arbiter.sv
// Shares one combinational 32-bit ALU between NUM_REQ requesters using round-robin
// arbitration with an optional per-requester lock, and a single-entry response register.
module alu_share_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int LOCK_TIMEOUT = 16,
   parameter int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ-1:0]    req_lock,
   input  logic [NUM_REQ*32-1:0] req_a,
   input  logic [NUM_REQ*32-1:0] req_b,
   input  logic [NUM_REQ*3-1:0]  req_ctrl,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   output logic [2:0]            alu_ctrl,
   input  logic [31:0]           alu_result,
   input  logic                  alu_zero,
   input  logic                  alu_carry,
   input  logic                  alu_overflow,
   input  logic                  alu_negative,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [31:0]           rsp_result,
   output logic [3:0]            rsp_flags
);

   localparam int LCW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

   typedef enum logic {ARB, LOCKED} state_t;

   state_t           r_state;
   logic [IDW-1:0]   r_owner;
   logic [IDW-1:0]   r_rrPtr;
   logic [LCW-1:0]   r_lockCnt;
   logic             r_rspValid;
   logic [IDW-1:0]   r_rspId;
   logic [31:0]      r_rspResult;
   logic [3:0]       r_rspFlags;

   logic [IDW-1:0]   w_grantIdx;
   logic             w_grantFound;
   logic             w_canAccept;
   logic             w_accept;

   function automatic logic [IDW-1:0] nextIdx(input logic [IDW-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
   endfunction

   // While locked only the owner competes; otherwise search upward from the rr pointer.
   always_comb begin
      int searchIdx;
      w_grantIdx   = '0;
      w_grantFound = 1'b0;
      searchIdx    = 0;
      if (r_state == LOCKED) begin
         w_grantIdx   = r_owner;
         w_grantFound = req_valid[r_owner];
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            searchIdx = (int'(r_rrPtr) + k) % NUM_REQ;
            if (!w_grantFound && req_valid[searchIdx]) begin
               w_grantFound = 1'b1;
               w_grantIdx   = IDW'(searchIdx);
            end
         end
      end
   end

   assign w_canAccept = rst_n & (~r_rspValid | rsp_ready);
   assign w_accept    = w_canAccept & w_grantFound;

   assign req_ready = w_accept ? (NUM_REQ'(1) << w_grantIdx) : '0;
   assign alu_a     = w_accept ? req_a[32*w_grantIdx +: 32] : '0;
   assign alu_b     = w_accept ? req_b[32*w_grantIdx +: 32] : '0;
   assign alu_ctrl  = w_accept ? req_ctrl[3*w_grantIdx +: 3] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rspValid  <= 1'b0;
         r_rspId     <= '0;
         r_rspResult <= '0;
         r_rspFlags  <= '0;
      end else if (w_accept) begin
         r_rspValid  <= 1'b1;
         r_rspId     <= w_grantIdx;
         r_rspResult <= alu_result;
         r_rspFlags  <= {alu_negative, alu_zero, alu_carry, alu_overflow};
      end else if (rsp_ready) begin
         r_rspValid  <= 1'b0;
      end
   end

   // Lock bookkeeping: the pointer only moves past an owner once its lock is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ARB;
         r_owner   <= '0;
         r_rrPtr   <= '0;
         r_lockCnt <= '0;
      end else begin
         case (r_state)
            ARB: begin
               if (w_accept) begin
                  if (req_lock[w_grantIdx]) begin
                     r_state   <= LOCKED;
                     r_owner   <= w_grantIdx;
                     r_lockCnt <= '0;
                  end else begin
                     r_rrPtr <= nextIdx(w_grantIdx);
                  end
               end
            end
            LOCKED: begin
               if (w_accept && !req_lock[r_owner]) begin
                  r_state   <= ARB;
                  r_rrPtr   <= nextIdx(r_owner);
                  r_lockCnt <= '0;
               end else if (req_valid[r_owner]) begin
                  r_lockCnt <= '0;
               end else if (LOCK_TIMEOUT != 0) begin
                  if (r_lockCnt == LCW'(LOCK_TIMEOUT - 1)) begin
                     r_state   <= ARB;
                     r_rrPtr   <= nextIdx(r_owner);
                     r_lockCnt <= '0;
                  end else begin
                     r_lockCnt <= r_lockCnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign rsp_valid  = r_rspValid;
   assign rsp_id     = r_rspId;
   assign rsp_result = r_rspResult;
   assign rsp_flags  = r_rspFlags;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a behavioural ALU answers the DUT, and the
// expected responses are queued as requests are driven and compared on each handshake.
module tb_alu_share_arbiter;

   logic           clk;
   logic           rst_n;
   logic [3:0]     req_valid;
   logic [3:0]     req_ready;
   logic [3:0]     req_lock;
   logic [127:0]   req_a;
   logic [127:0]   req_b;
   logic [11:0]    req_ctrl;
   logic [31:0]    alu_a;
   logic [31:0]    alu_b;
   logic [2:0]     alu_ctrl;
   logic [31:0]    alu_result;
   logic           alu_zero;
   logic           alu_carry;
   logic           alu_overflow;
   logic           alu_negative;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [31:0]    rsp_result;
   logic [3:0]     rsp_flags;

   logic [31:0]    opA [4];
   logic [31:0]    opB [4];
   logic [2:0]     opCtrl [4];
   logic [35:0]    aluOut;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] result;
      logic [3:0]  flags;
   } expT;

   expT expQ[$];
   expT popped;
   int  checkCount = 0;
   int  errorCount = 0;

   alu_share_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
      .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .alu_overflow(alu_overflow), .alu_negative(alu_negative),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: returns {N,Z,C,V,result}.
   function automatic logic [35:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] ctrl);
      logic [32:0] sum;
      logic [31:0] r;
      logic        c;
      logic        v;
      sum = '0;
      r   = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (ctrl)
         3'b000: begin
            sum = {1'b0, a} + {1'b0, b};
            r   = sum[31:0];
            c   = sum[32];
            v   = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'b001: begin
            sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r   = sum[31:0];
            c   = sum[32];
            v   = (a[31] != b[31]) && (r[31] != a[31]);
         end
         3'b010: r = a & b;
         3'b011: r = a | b;
         3'b101: r = {31'b0, $signed(a) < $signed(b)};
         default: r = '0;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   assign aluOut       = aluModel(alu_a, alu_b, alu_ctrl);
   assign alu_result   = aluOut[31:0];
   assign alu_negative = aluOut[35];
   assign alu_zero     = aluOut[34];
   assign alu_carry    = aluOut[33];
   assign alu_overflow = aluOut[32];

   always_comb begin
      req_a    = '0;
      req_b    = '0;
      req_ctrl = '0;
      for (int i = 0; i < 4; i++) begin
         req_a[32*i +: 32] = opA[i];
         req_b[32*i +: 32] = opB[i];
         req_ctrl[3*i +: 3] = opCtrl[i];
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] lock,
                                input logic rspReady);
      req_valid = valid;
      req_lock  = lock;
      rsp_ready = rspReady;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input int i);
      logic [35:0] m;
      m = aluModel(opA[i], opB[i], opCtrl[i]);
      expQ.push_back('{id: 2'(i), result: m[31:0], flags: m[35:32]});
   endtask

   // Response monitor: every handshake pops the oldest expected response.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("sbUnderflow", 64'(expQ.size()), 64'd1);
         end else begin
            popped = expQ.pop_front();
            checkOutput("rspId", 64'(rsp_id), 64'(popped.id));
            checkOutput("rspResult", 64'(rsp_result), 64'(popped.result));
            checkOutput("rspFlags", 64'(rsp_flags), 64'(popped.flags));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      opA[0] = 32'd5;          opB[0] = 32'd3;          opCtrl[0] = 3'b000;
      opA[1] = 32'h7FFF_FFFF;  opB[1] = 32'd1;          opCtrl[1] = 3'b000;
      opA[2] = 32'd3;          opB[2] = 32'd3;          opCtrl[2] = 3'b001;
      opA[3] = 32'hF0F0_F0F0;  opB[3] = 32'hFF00_FF00;  opCtrl[3] = 3'b010;
      rst_n = 1'b0;
      applyStimulus(4'b1111, 4'b0000, 1'b1);

      #3;
      checkOutput("resetReqReady", 64'(req_ready), 64'd0);
      checkOutput("resetAluA", 64'(alu_a), 64'd0);
      checkOutput("resetAluCtrl", 64'(alu_ctrl), 64'd0);
      checkOutput("resetRspValid", 64'(rsp_valid), 64'd0);
      checkOutput("resetRspId", 64'(rsp_id), 64'd0);
      checkOutput("resetRspResult", 64'(rsp_result), 64'd0);
      checkOutput("resetRspFlags", 64'(rsp_flags), 64'd0);
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      nextCycle();

      $display("[TB] round-robin stream");
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      for (int k = 0; k < 6; k++) begin
         pushExp(k % 4);
         #1;
         checkOutput("rrReady", 64'(req_ready), 64'(1 << (k % 4)));
         if (k > 0) checkOutput("rrNoBubble", 64'(rsp_valid), 64'd1);
         nextCycle();
      end
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      #1;
      checkOutput("rrLastValid", 64'(rsp_valid), 64'd1);
      nextCycle();

      $display("[TB] single add, latency");
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      pushExp(0);
      #1;
      checkOutput("addReady", 64'(req_ready), 64'd1);
      checkOutput("addAluA", 64'(alu_a), 64'd5);
      checkOutput("addAluB", 64'(alu_b), 64'd3);
      checkOutput("addAluCtrl", 64'(alu_ctrl), 64'd0);
      nextCycle();
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      #1;
      checkOutput("addRspValid", 64'(rsp_valid), 64'd1);
      checkOutput("addRspId", 64'(rsp_id), 64'd0);
      checkOutput("addRspResult", 64'(rsp_result), 64'd8);
      checkOutput("addZeroFlag", 64'(rsp_flags[2]), 64'd0);
      nextCycle();
      #1;
      checkOutput("addRspDrop", 64'(rsp_valid), 64'd0);

      $display("[TB] sub then backpressure");
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      pushExp(2);
      #1;
      checkOutput("subReady", 64'(req_ready), 64'b0100);
      nextCycle();
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      pushExp(0);
      for (int j = 0; j < 3; j++) begin
         #1;
         checkOutput("stallRspValid", 64'(rsp_valid), 64'd1);
         checkOutput("stallRspId", 64'(rsp_id), 64'd2);
         checkOutput("stallRspResult", 64'(rsp_result), 64'd0);
         checkOutput("stallZeroFlag", 64'(rsp_flags[2]), 64'd1);
         checkOutput("stallNegFlag", 64'(rsp_flags[3]), 64'd0);
         checkOutput("stallReqReady", 64'(req_ready), 64'd0);
         checkOutput("stallAluA", 64'(alu_a), 64'd0);
         nextCycle();
      end
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      #1;
      checkOutput("releaseReady", 64'(req_ready), 64'b0001);
      nextCycle();
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      #1;
      checkOutput("releaseNoBubble", 64'(rsp_valid), 64'd1);
      checkOutput("releaseRspId", 64'(rsp_id), 64'd0);
      nextCycle();

      $display("[TB] locked sequence");
      applyStimulus(4'b0011, 4'b0010, 1'b1);
      pushExp(1);
      #1;
      checkOutput("lockReady1", 64'(req_ready), 64'b0010);
      nextCycle();
      applyStimulus(4'b0011, 4'b0010, 1'b1);
      pushExp(1);
      #1;
      checkOutput("lockReady2", 64'(req_ready), 64'b0010);
      nextCycle();
      applyStimulus(4'b0011, 4'b0000, 1'b1);
      pushExp(1);
      #1;
      checkOutput("lockReady3", 64'(req_ready), 64'b0010);
      nextCycle();
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      pushExp(0);
      #1;
      checkOutput("unlockReady", 64'(req_ready), 64'b0001);
      nextCycle();
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      nextCycle();

      $display("[TB] lock timeout");
      applyStimulus(4'b0011, 4'b0010, 1'b1);
      pushExp(1);
      #1;
      checkOutput("toLockReady", 64'(req_ready), 64'b0010);
      for (int c = 1; c <= 16; c++) begin
         nextCycle();
         applyStimulus(4'b0001, 4'b0000, 1'b1);
         #1;
         checkOutput("toHeldOff", 64'(req_ready), 64'd0);
      end
      nextCycle();
      pushExp(0);
      #1;
      checkOutput("toReleased", 64'(req_ready), 64'b0001);
      nextCycle();
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      nextCycle();

      $display("[TB] reset while locked with pending response");
      applyStimulus(4'b1000, 4'b1000, 1'b1);
      pushExp(3);
      #1;
      checkOutput("rstLockReady", 64'(req_ready), 64'b1000);
      nextCycle();
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      #1;
      checkOutput("rstPending", 64'(rsp_valid), 64'd1);
      rst_n = 1'b0;
      expQ.delete();
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      #1;
      checkOutput("rstRspValid", 64'(rsp_valid), 64'd0);
      checkOutput("rstRspId", 64'(rsp_id), 64'd0);
      checkOutput("rstRspResult", 64'(rsp_result), 64'd0);
      checkOutput("rstReqReady", 64'(req_ready), 64'd0);
      checkOutput("rstAluB", 64'(alu_b), 64'd0);
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(4'b1000, 4'b0000, 1'b1);
      pushExp(3);
      #1;
      checkOutput("postRstReady3", 64'(req_ready), 64'b1000);
      nextCycle();
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      pushExp(0);
      #1;
      checkOutput("postRstWrap0", 64'(req_ready), 64'b0001);
      nextCycle();
      pushExp(1);
      #1;
      checkOutput("postRstNext1", 64'(req_ready), 64'b0010);
      nextCycle();
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      nextCycle();
      nextCycle();

      checkOutput("sbDrain", 64'(expQ.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
